// File: rtl/rx_ack_scheduler.sv
// RX read-return sequencer: per-switch outstanding-op counters plus one-hot ack arbitration.
// Build option: define RX_ACK_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module rx_ack_scheduler #(
    parameter int NUM_SW_INST = 5,
    parameter int FIFO_SIZE   = 2,
    parameter int ACK_GAP     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SW_INST-1:0]         sel_en,
    input  logic [NUM_SW_INST-1:0]         done,
    output logic [NUM_SW_INST-1:0]         ack,
    output logic [$clog2(NUM_SW_INST)-1:0] ack_idx,
    output logic [NUM_SW_INST-1:0]         sw_full,
    output logic                           idle,
    output logic                           err_ovf,
    output logic                           err_spur
);
    localparam int IDX_W  = $clog2(NUM_SW_INST);
    localparam int IDX_W1 = IDX_W + 1;
    localparam int CNT_W  = $clog2(FIFO_SIZE + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_SIZE);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_SW_INST - 1);
    localparam logic [IDX_W1-1:0] NUM_EXT  = IDX_W1'(NUM_SW_INST);
    localparam logic [3:0]        GAP_LAST = (ACK_GAP > 0) ? 4'(ACK_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t                               state_reg, state_next;
    logic [NUM_SW_INST-1:0]               ack_reg, ack_next;
    logic [IDX_W-1:0]                     ack_idx_reg, ack_idx_next;
    logic [IDX_W-1:0]                     rr_reg, rr_next;
    logic [3:0]                           gap_reg, gap_next;
    logic [NUM_SW_INST-1:0][CNT_W-1:0]    cnt_reg, cnt_next;
    logic [NUM_SW_INST-1:0]               spur_seen_reg, spur_seen_next;
    logic                                 err_ovf_reg, err_spur_reg;

    logic [NUM_SW_INST-1:0] nonzero, eligible, ovf_hit, inc, dec;
    logic [NUM_SW_INST-1:0] spur_cand, spur_new;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W1-1:0]      pos;
    logic                   any_eligible;

    // sel_en and ack together leave the count untouched, so a full counter is not an overflow then.
    for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_sw
        assign nonzero[gi]  = (cnt_reg[gi] != '0);
        assign sw_full[gi]  = (cnt_reg[gi] == CNT_FULL);
        assign inc[gi]      = sel_en[gi] & ~ack_reg[gi] & ~sw_full[gi];
        assign dec[gi]      = ack_reg[gi] & ~sel_en[gi];
        assign ovf_hit[gi]  = sel_en[gi] & ~ack_reg[gi] & sw_full[gi];
        assign cnt_next[gi] = inc[gi] ? cnt_reg[gi] + 1'b1 :
                              dec[gi] ? cnt_reg[gi] - 1'b1 : cnt_reg[gi];
    end

    assign eligible  = done & nonzero;
    assign spur_cand = done & ~nonzero;
    // Report each spurious done once per episode rather than every cycle it is held.
    assign spur_new       = (state_reg == IDLE) ? (spur_cand & ~spur_seen_reg) : '0;
    assign spur_seen_next = (spur_seen_reg | spur_new) & spur_cand;

    // Fixed-priority builds keep rr_reg at zero, which turns this search into lowest-index-wins.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        pos          = '0;
        for (int k = 0; k < NUM_SW_INST; k++) begin
            pos = {1'b0, rr_reg} + IDX_W1'(k);
            if (pos >= NUM_EXT) pos = pos - NUM_EXT;
            if (!any_eligible && eligible[pos[IDX_W-1:0]]) begin
                any_eligible = 1'b1;
                winner       = pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        ack_next     = '0;
        ack_idx_next = ack_idx_reg;
        rr_next      = rr_reg;
        gap_next     = gap_reg;
        case (state_reg)
            IDLE: begin
                if (any_eligible) begin
                    ack_next[winner] = 1'b1;
                    ack_idx_next     = winner;
                    state_next       = GRANT;
                end
            end
            GRANT: begin
`ifdef RX_ACK_FIXED_PRIO_EN
                rr_next = '0;
`else
                rr_next = (ack_idx_reg == IDX_LAST) ? '0 : ack_idx_reg + 1'b1;
`endif
                gap_next   = '0;
                state_next = (ACK_GAP > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_reg == GAP_LAST) state_next = IDLE;
                else                     gap_next   = gap_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ack_reg       <= '0;
            ack_idx_reg   <= '0;
            rr_reg        <= '0;
            gap_reg       <= '0;
            cnt_reg       <= '0;
            spur_seen_reg <= '0;
            err_ovf_reg   <= 1'b0;
            err_spur_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ack_reg       <= ack_next;
            ack_idx_reg   <= ack_idx_next;
            rr_reg        <= rr_next;
            gap_reg       <= gap_next;
            cnt_reg       <= cnt_next;
            spur_seen_reg <= spur_seen_next;
            err_ovf_reg   <= |ovf_hit;
            err_spur_reg  <= |spur_new;
        end
    end

    assign ack      = ack_reg;
    assign ack_idx  = ack_idx_reg;
    assign err_ovf  = err_ovf_reg;
    assign err_spur = err_spur_reg;
    assign idle     = (state_reg == IDLE) && (nonzero == '0);
endmodule

// File: tb/tb_rx_ack_scheduler.sv
// Directed bench for rx_ack_scheduler: expected grant indices are queued at stimulus time and
// popped by a monitor whenever ack fires; status outputs are checked at fixed points.
module tb_rx_ack_scheduler;
    localparam int N = 5;

    logic         clk, rst;
    logic [N-1:0] sel_en, done, ack, sw_full;
    logic [2:0]   ack_idx;
    logic         idle, err_ovf, err_spur;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mon_exp;
    int exp_q[$];

    rx_ack_scheduler #(.NUM_SW_INST(N), .FIFO_SIZE(2), .ACK_GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_en   (sel_en),
        .done     (done),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .sw_full  (sw_full),
        .idle     (idle),
        .err_ovf  (err_ovf),
        .err_spur (err_spur)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        $display("t=%0t cyc=%0d %s: got %0h want %0h", $time, cyc, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for the next grant; returns the cycle on which ack was seen.
    task automatic wait_ack(input string tag, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack === '0 && n < 12);
        chk({tag, "_seen"}, 32'(ack !== '0), 32'd1);
        at = cyc;
    endtask

    // Scoreboard: every ack must match the next queued index.
    always @(negedge clk) begin
        if (!rst && ack !== '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("ack_onehot", 32'(ack), 32'd1 << mon_exp);
                chk("ack_idx", 32'(ack_idx), 32'(mon_exp));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, at, prev;
        rst    = 1'b1;
        sel_en = '0;
        done   = '0;
        step(2);
        chk("rst_ack",      32'(ack),      32'd0);
        chk("rst_ack_idx",  32'(ack_idx),  32'd0);
        chk("rst_sw_full",  32'(sw_full),  32'd0);
        chk("rst_idle",     32'(idle),     32'd1);
        chk("rst_err_ovf",  32'(err_ovf),  32'd0);
        chk("rst_err_spur", 32'(err_spur), 32'd0);
        rst = 1'b0;
        step(1);

        // Single op on switch 1: one-cycle latency, single-cycle pulse, back to idle.
        sel_en = 5'b00010;
        exp_q.push_back(1);
        step(1);
        sel_en = '0;
        done   = 5'b00010;
        c0     = cyc;
        wait_ack("single", at);
        chk("single_latency", 32'(at - c0), 32'd1);
        done = '0;
        step(1);
        chk("single_pulse", 32'(ack), 32'd0);
        step(1);
        chk("single_idle", 32'(idle), 32'd1);

        // Spurious done on switch 4 with nothing outstanding.
        done = 5'b10000;
        step(1);
        chk("spur_pulse",  32'(err_spur), 32'd1);
        chk("spur_no_ack", 32'(ack),      32'd0);
        step(1);
        chk("spur_once",   32'(err_spur), 32'd0);
        chk("spur_idle",   32'(idle),     32'd1);
        done = '0;

        // Three issues to switch 2: full after the second, overflow pulse for the third.
        sel_en = 5'b00100;
        step(1);
        chk("ovf_full_after1", 32'(sw_full), 32'd0);
        step(1);
        chk("ovf_full_after2", 32'(sw_full), 32'h04);
        chk("ovf_none_yet",    32'(err_ovf), 32'd0);
        step(1);
        sel_en = '0;
        chk("ovf_pulse",       32'(err_ovf), 32'd1);
        chk("ovf_full_hold",   32'(sw_full), 32'h04);
        step(1);
        chk("ovf_once",        32'(err_ovf), 32'd0);

        // Fill switch 3, then issue again in the same cycle its ack is high.
        sel_en = 5'b01000;
        step(2);
        sel_en = '0;
        chk("coinc_full", 32'(sw_full), 32'h0C);
        done = 5'b01000;
        repeat (3) exp_q.push_back(3);
        wait_ack("coinc_grant", at);
        sel_en = 5'b01000;
        step(1);
        sel_en = '0;
        chk("coinc_cnt_held", 32'(sw_full), 32'h0C);
        chk("coinc_no_ovf",   32'(err_ovf), 32'd0);
        wait_ack("drain3_a", at);
        wait_ack("drain3_b", at);
        done = 5'b00100;
        repeat (2) exp_q.push_back(2);
        wait_ack("drain2_a", at);
        wait_ack("drain2_b", at);
        done = '0;
        step(3);
        chk("drain_idle",    32'(idle),    32'd1);
        chk("drain_sw_full", 32'(sw_full), 32'd0);

        // Reset while a grant is on the wire.
        sel_en = 5'b00100;
        exp_q.push_back(2);
        step(1);
        sel_en = '0;
        done   = 5'b00100;
        wait_ack("rst_mid", at);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ack",  32'(ack),     32'd0);
        chk("rst_mid_idle", 32'(idle),    32'd1);
        chk("rst_mid_idx",  32'(ack_idx), 32'd0);
        done = '0;
        step(2);
        rst = 1'b0;
        step(1);
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_ack",  32'(ack),  32'd0);

        // One op per switch, all done together: ascending order, one ack every three cycles.
        sel_en = '1;
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        step(1);
        sel_en = '0;
        done   = '1;
        c0     = cyc;
        prev   = c0;
        for (int i = 0; i < N; i++) begin
            wait_ack("all_sw", at);
            if (i == 0) chk("all_first_latency", 32'(at - c0), 32'd1);
            else        chk("all_spacing", 32'(at - prev), 32'd3);
            prev = at;
            done = done & ~ack;
        end
        step(3);
        chk("all_idle", 32'(idle), 32'd1);

        // Two ops on switch 0, one on switch 1, both done held: arbitration order.
        sel_en = 5'b00011;
        step(1);
        sel_en = 5'b00001;
        step(1);
        sel_en = '0;
        chk("arb_sw_full", 32'(sw_full), 32'h01);
`ifdef RX_ACK_FIXED_PRIO_EN
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(1);
`else
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
`endif
        done = 5'b00011;
        for (int i = 0; i < 3; i++) wait_ack("arb", at);
        done = '0;
        step(3);
        chk("final_idle",  32'(idle),         32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
